// File: rtl/collapse_read_arbiter.sv
// Sequencer and round-robin read arbiter for a byte-wide read-once collapse cell.
// Optional armed-lifetime expiry is built when COLLAPSE_ARB_TIMEOUT_EN is defined.
module collapse_read_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prov_valid,
   output logic              prov_ready,
   input  logic [7:0]        prov_value,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [2*NREQ-1:0] req_basis,
   output logic [NREQ-1:0]   resp_valid,
   output logic [7:0]        resp_data,
   output logic              resp_ok,
   output logic              cell_init,
   output logic              cell_read,
   output logic [7:0]        cell_value_in,
   output logic [1:0]        cell_read_basis,
   input  logic [7:0]        cell_value_out,
   input  logic              cell_output_enable,
   output logic              armed,
   output logic              spent,
   output logic              expired
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [2:0] {
      S_UNARMED, S_INIT, S_ARMED, S_READ, S_RESP, S_SPENT, S_DENY, S_EXPIRE
   } state_t;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_param_check
      $error("collapse_read_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
   end

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_grant;
   logic [IW-1:0]   w_pick;
   logic [IW-1:0]   w_grant_nxt;
   logic [IW:0]     w_sum;
   logic            w_any;
   logic [1:0]      w_basis;
   logic [7:0]      r_val;
   logic [1:0]      r_basis;
   logic [7:0]      r_resp_data;
   logic            r_resp_ok;
   logic            w_timeout;

`ifdef COLLAPSE_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT);
   logic [CW-1:0]   r_cnt;
   logic            r_expired;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_expired <= 1'b0;
      end else begin
         if (r_state == S_INIT) begin
            r_cnt <= '0;
         end else if (r_state == S_ARMED) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (r_state == S_EXPIRE) begin
            r_expired <= 1'b1;
         end
      end
   end

   assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
   assign expired   = r_expired;
`else
   assign w_timeout = 1'b0;
   assign expired   = 1'b0;
`endif

   // Walk offsets from the highest down so the lowest offset from the pointer wins.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_sum  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_ptr} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(NREQ)) begin
            w_sum = w_sum - (IW+1)'(NREQ);
         end
         if (req_valid[w_sum[IW-1:0]]) begin
            w_any  = 1'b1;
            w_pick = w_sum[IW-1:0];
         end
      end
   end

   always_comb begin
      w_basis = 2'b00;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick == IW'(i)) begin
            w_basis = req_basis[2*i +: 2];
         end
      end
   end

   assign w_grant_nxt = (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + IW'(1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_UNARMED: if (prov_valid) w_next = S_INIT;
         S_INIT:    w_next = S_ARMED;
         S_ARMED: begin
            if (w_any) begin
               w_next = S_READ;
            end else if (w_timeout) begin
               w_next = S_EXPIRE;
            end
         end
         S_READ:    w_next = S_RESP;
         S_RESP:    w_next = S_SPENT;
         S_SPENT:   if (w_any) w_next = S_DENY;
         S_DENY:    w_next = S_SPENT;
         S_EXPIRE:  w_next = S_SPENT;
         default:   w_next = S_UNARMED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_UNARMED;
         r_ptr   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_RESP || r_state == S_DENY) begin
            r_ptr <= w_grant_nxt;
         end
      end
   end

   // Secret-bearing registers are scrubbed as soon as their one use has passed.
   always_ff @(posedge clk) begin
      if (r_state == S_UNARMED && prov_valid) begin
         r_val <= prov_value;
      end else if (r_state == S_INIT) begin
         r_val <= '0;
      end
      if ((r_state == S_ARMED || r_state == S_SPENT) && w_any) begin
         r_grant <= w_pick;
      end
      if (r_state == S_ARMED && w_any) begin
         r_basis <= w_basis;
      end else if (r_state == S_READ) begin
         r_basis <= 2'b00;
      end
      r_resp_data <= (r_state == S_READ) ? cell_value_out : 8'h00;
      r_resp_ok   <= (r_state == S_READ) && cell_output_enable;
   end

   always_comb begin
      prov_ready      = (r_state == S_UNARMED);
      cell_init       = (r_state == S_INIT);
      cell_value_in   = (r_state == S_INIT) ? r_val : 8'h00;
      cell_read       = (r_state == S_READ) || (r_state == S_EXPIRE);
      cell_read_basis = (r_state == S_READ) ? r_basis : 2'b00;
      armed           = (r_state == S_ARMED);
      spent           = (r_state == S_SPENT);
      resp_data       = (r_state == S_RESP) ? r_resp_data : 8'h00;
      resp_ok         = (r_state == S_RESP) && r_resp_ok;
      resp_valid      = '0;
      for (int i = 0; i < NREQ; i++) begin
         resp_valid[i] = (r_state == S_RESP || r_state == S_DENY) && (r_grant == IW'(i));
      end
   end

endmodule

// File: doc/collapse_read_arbiter.md
# collapse_read_arbiter

Sequencing controller and requester arbiter for one byte-wide read-once collapse register cell. It provisions the cell through a ready/valid port and grants its single destructive read to one of `NREQ` requesters, chosen round-robin. It returns the one-shot result, then denies all later requests without touching the cell. It sits between the provisioning/host fabric and the cell, and owns every `init`/`read` strobe the cell receives.

## Interface
- `NREQ`, 4: number of read requesters (2..8).
- `TIMEOUT`, 1024: armed-lifetime limit in cycles. Used only with `COLLAPSE_ARB_TIMEOUT_EN`.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `prov_valid` / `prov_ready`  in/out  1 / 1: provisioning handshake.
- `prov_value`  in  8: secret byte to load.
- `req_valid`  in  NREQ: per-requester read request, level-held until that requester's `resp_valid`.
- `req_basis`  in  2*NREQ: requester i's basis on bits [2i+1:2i].
- `resp_valid`  out  NREQ: one-hot, 1-cycle response strobe.
- `resp_data`  out  8: returned byte, valid with `resp_valid`.
- `resp_ok`  out  1: 1 means `resp_data` is the true secret.
- `cell_init`, `cell_read`  out  1: cell strobes.
- `cell_value_in`  out  8 and `cell_read_basis`  out  2: cell data and basis inputs.
- `cell_value_out`  in  8 and `cell_output_enable`  in  1: cell outputs, combinational within the read cycle.
- `armed`, `spent`, `expired`  out  1: status.

## Operation
- States: UNARMED, INIT, ARMED, READ, RESP, SPENT, DENY, and EXPIRE (macro only).
- **UNARMED**
  - `prov_ready`=1.
  - On `prov_valid`: latch `prov_value` and go to INIT.
  - Requests wait; none are granted.
- **INIT** (1 cycle)
  - `cell_init`=1 and `cell_value_in`=latched value.
  - Clear the latch to 0 on exit, then go to ARMED.
- **ARMED**
  - `armed`=1.
  - If any `req_valid` is set, grant the first requester at or after the round-robin pointer.
  - Latch the grant index and that requester's basis, then go to READ.
- **READ** (1 cycle)
  - `cell_read`=1 and `cell_read_basis`=latched basis.
  - At the closing edge, register `resp_data`=`cell_value_out` and `resp_ok`=`cell_output_enable`.
  - Go to RESP.
- **RESP** (1 cycle)
  - `resp_valid[grant]`=1.
  - Advance the pointer to grant+1 mod NREQ and go to SPENT.
- **SPENT** (terminal until reset)
  - `spent`=1.
  - `prov_ready`=0; a new provision is refused.
  - Any request is arbitrated round-robin and goes to DENY.
- **DENY** (1 cycle)
  - `resp_valid[grant]`=1, `resp_ok`=0, `resp_data`=8'h00.
  - No `cell_read` is issued, so no obfuscation bytes leak.
  - Advance the pointer and return to SPENT.
- **Data-hygiene rules**
  - `cell_value_in`=0 outside INIT.
  - `cell_read_basis`=0 outside READ/EXPIRE.
  - `resp_data`/`resp_ok` are 0 in every state except RESP and DENY.
- `prov_valid` outside UNARMED is ignored.
- A requester that drops `req_valid` before its response is a protocol violation. The grant stands and the cell is still read.
- Only ARMED is exited to READ. Exactly one `cell_read` is issued per provision.

## Timing
- **Reset values**
  - State = UNARMED and round-robin pointer = 0.
  - All outputs are 0 except `prov_ready`=1.
- Provision latency: handshake accepted at edge E0 → `cell_init` high during cycle E0..E1 → `armed` from E1.
- Read latency: `req_valid` sampled in ARMED at edge E0 → `cell_read` high during E0..E1 → `resp_valid` high during E1..E2.
- DENY latency: `resp_valid` high during the cycle after the SPENT sampling edge.
- Back-to-back denies to the same requester are separated by at least 1 SPENT cycle.
- Simultaneous requests: round-robin from the pointer, so the lowest index wins after reset.
- Reset mid-operation (any state, including READ) returns to UNARMED next edge. Any pending response is dropped.

## Configuration
- **`COLLAPSE_ARB_TIMEOUT_EN` defined**
  - A counter of width clog2(TIMEOUT) clears on entry to ARMED and increments each ARMED cycle.
  - At count TIMEOUT-1 with no `req_valid`, go to EXPIRE.
  - EXPIRE (1 cycle): `cell_read`=1, `cell_read_basis`=2'b00. Cell output is discarded. Set `expired`=1, sticky until reset. Go to SPENT.
  - A request in the expiry cycle wins over expiry.
- **Not defined:** ARMED holds indefinitely, `expired` is tied 0, and no counter exists.

## Test plan
- **Happy path:** reset; provision 8'h3C; req0 with the basis that matches the cell → `resp_valid`=4'b0001 two cycles after sampling, `resp_ok`=1, `resp_data`=8'h3C, exactly one `cell_read` pulse.
- **Wrong basis:** provision 8'h5A; req2 with a mismatched basis → `resp_ok`=0, `resp_data`≠8'h5A, `spent`=1.
- **Contention:** all requesters request together → req0 gets the read. Then req1, req2 and req3 each get a DENY in that order (`resp_ok`=0, data 8'h00), with no further `cell_read`.
- **Provisioning refusal:** `prov_valid` in ARMED and in SPENT → `prov_ready`=0, no `cell_init`, `cell_value_in` stays 0.
- **Reset in READ:** `reset` asserted during the READ cycle → next cycle state UNARMED, `resp_valid`=0, `prov_ready`=1.
- **Timeout (macro on, TIMEOUT=16):** provision, no requests → `cell_read` in cycle 16 of ARMED with basis 2'b00, then `expired`=1 and `spent`=1. A later request → DENY.
